alu_input_ctrl: RTL and testbench

ALU_INPUT_CTRL -- requirements
Module: alu_input_ctrl

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_input_ctrl_if.sv | 32 +++
 rtl/btn_debounce.sv | 51 +++++
 rtl/alu_input_ctrl.sv | 96 +++++++++
 tb/tb_alu_input_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg -- opcode encodings and input-controller FSM states shared with the ALU
// Rev 1.0
// ============================================================================
package alu_pkg;

    localparam int OPCODE_W = 6;

    typedef logic [OPCODE_W-1:0] opcode_t;

    localparam opcode_t c_op_add = 6'b100000;
    localparam opcode_t c_op_sub = 6'b100010;
    localparam opcode_t c_op_and = 6'b100100;
    localparam opcode_t c_op_or  = 6'b100101;
    localparam opcode_t c_op_xor = 6'b100110;
    localparam opcode_t c_op_sra = 6'b000011;
    localparam opcode_t c_op_srl = 6'b000010;
    localparam opcode_t c_op_nor = 6'b100111;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        ARMED = 1'b1
    } ctrl_state_t;

    // Widened compare so callers with any opcode width up to 32 bits can use it;
    // nonzero upper bits never match a legal code.
    function automatic logic is_legal_opcode(input logic [31:0] code);
        return (code == 32'(c_op_add)) || (code == 32'(c_op_sub)) ||
               (code == 32'(c_op_and)) || (code == 32'(c_op_or))  ||
               (code == 32'(c_op_xor)) || (code == 32'(c_op_sra)) ||
               (code == 32'(c_op_srl)) || (code == 32'(c_op_nor));
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_input_ctrl_if.sv
`default_nettype none
// ============================================================================
// alu_input_ctrl_if -- switch/button inputs and latched operand outputs
// Rev 1.0
// ============================================================================
interface alu_input_ctrl_if #(
    parameter int NB_OPERANDO = 8,
    parameter int NB_OPCODE   = 6
);
    logic [NB_OPERANDO-1:0] i_switch;
    logic                   i_boton_1;
    logic                   i_boton_2;
    logic                   i_boton_3;
    logic                   i_boton_4;
    logic [NB_OPERANDO-1:0] o_dato_a;
    logic [NB_OPERANDO-1:0] o_dato_b;
    logic [NB_OPCODE-1:0]   o_opcode;
    logic [2:0]             o_loaded;
    logic                   o_valid;
    logic                   o_err;

    modport master (
        output i_switch, i_boton_1, i_boton_2, i_boton_3, i_boton_4,
        input  o_dato_a, o_dato_b, o_opcode, o_loaded, o_valid, o_err
    );

    modport slave (
        input  i_switch, i_boton_1, i_boton_2, i_boton_3, i_boton_4,
        output o_dato_a, o_dato_b, o_opcode, o_loaded, o_valid, o_err
    );
endinterface
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// btn_debounce -- 2-flop synchronizer, counting debouncer, rising-edge pulse
// Rev 1.0
// ============================================================================
module btn_debounce #(
    parameter int N_DEBOUNCE = 2
) (
    input  wire  i_clk,
    input  wire  i_reset,
    input  wire  i_btn,
    output logic o_press
);

    // Toggling on the N-th mismatching cycle means the count never needs to hold N itself.
    localparam logic [7:0] c_last = 8'(N_DEBOUNCE - 1);

    logic       r_sync_1;
    logic       r_sync_2;
    logic       r_level;
    logic       r_level_d;
    logic [7:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_sync_1  <= 1'b0;
            r_sync_2  <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync_1  <= i_btn;
            r_sync_2  <= r_sync_1;
            r_level_d <= r_level;
            if (r_sync_2 != r_level) begin
                if (r_cnt == c_last) begin
                    r_level <= ~r_level;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_press = r_level & ~r_level_d;

endmodule
`default_nettype wire

// File: rtl/alu_input_ctrl.sv
`default_nettype none
// ============================================================================
// alu_input_ctrl -- loads A, B and opcode from switches via buttons, issues to ALU
// Rev 1.0
// ============================================================================
module alu_input_ctrl
    import alu_pkg::*;
#(
    parameter int NB_OPERANDO = 8,
    parameter int NB_OPCODE   = 6,
    parameter int N_DEBOUNCE  = 2
) (
    input  wire             i_clk,
    input  wire             i_reset,
    alu_input_ctrl_if.slave ctrl_bus
);

    logic [3:0]             w_btn_raw;
    logic [3:0]             w_press;
    logic [NB_OPCODE-1:0]   w_op_field;
    logic                   w_op_legal;
    logic [2:0]             w_loaded_nxt;
    logic                   w_err_nxt;

    logic [NB_OPERANDO-1:0] r_dato_a;
    logic [NB_OPERANDO-1:0] r_dato_b;
    logic [NB_OPCODE-1:0]   r_opcode;
    logic [2:0]             r_loaded;
    logic                   r_valid;
    logic                   r_err;
    ctrl_state_t            r_state;

    assign w_btn_raw = {ctrl_bus.i_boton_4, ctrl_bus.i_boton_3,
                        ctrl_bus.i_boton_2, ctrl_bus.i_boton_1};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_btn
            btn_debounce #(
                .N_DEBOUNCE (N_DEBOUNCE)
            ) u_btn (
                .i_clk   (i_clk),
                .i_reset (i_reset),
                .i_btn   (w_btn_raw[gi]),
                .o_press (w_press[gi])
            );
        end
    endgenerate

    assign w_op_field = ctrl_bus.i_switch[NB_OPCODE-1:0];
    assign w_op_legal = is_legal_opcode(32'(w_op_field));

    // Issue looks at r_state, i.e. the flags as they stood before this cycle's loads.
    always_comb begin
        w_loaded_nxt = r_loaded | {w_press[2] & w_op_legal, w_press[1], w_press[0]};
        w_err_nxt    = (w_press[2] & ~w_op_legal) | (w_press[3] & (r_state != ARMED));
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_dato_a <= '0;
            r_dato_b <= '0;
            r_opcode <= '0;
            r_loaded <= 3'b000;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            r_state  <= EMPTY;
        end else begin
            r_valid  <= w_press[3] & (r_state == ARMED);
            r_err    <= w_err_nxt;
            r_loaded <= w_loaded_nxt;
            if (w_press[0]) begin
                r_dato_a <= ctrl_bus.i_switch;
            end
            if (w_press[1]) begin
                r_dato_b <= ctrl_bus.i_switch;
            end
            if (w_press[2] && w_op_legal) begin
                r_opcode <= w_op_field;
            end
            case (r_state)
                EMPTY:   if (w_loaded_nxt == 3'b111) r_state <= ARMED;
                ARMED:   r_state <= ARMED;
                default: r_state <= EMPTY;
            endcase
        end
    end

    assign ctrl_bus.o_dato_a = r_dato_a;
    assign ctrl_bus.o_dato_b = r_dato_b;
    assign ctrl_bus.o_opcode = r_opcode;
    assign ctrl_bus.o_loaded = r_loaded;
    assign ctrl_bus.o_valid  = r_valid;
    assign ctrl_bus.o_err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_input_ctrl.sv
`default_nettype none
// ============================================================================
// tb_alu_input_ctrl -- directed stimulus against a behavioural model of the controller
// Rev 1.0
// ============================================================================
module tb_alu_input_ctrl;

    localparam int NB_OPERANDO = 8;
    localparam int NB_OPCODE   = 6;
    localparam int N_DEBOUNCE  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    alu_input_ctrl_if #(.NB_OPERANDO(NB_OPERANDO), .NB_OPCODE(NB_OPCODE)) bus ();

    alu_input_ctrl #(
        .NB_OPERANDO (NB_OPERANDO),
        .NB_OPCODE   (NB_OPCODE),
        .N_DEBOUNCE  (N_DEBOUNCE)
    ) dut (
        .i_clk    (clk),
        .i_reset  (rst_n),
        .ctrl_bus (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    bit [5:0] legal_codes [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h03, 6'h02, 6'h27};

    function automatic bit legal(input bit [5:0] code);
        for (int i = 0; i < 8; i++) if (legal_codes[i] == code) return 1'b1;
        return 1'b0;
    endfunction

    // Model: a button level flips once the last N synchronized samples all disagree with it.
    bit [7:0] m_a, m_b;
    bit [5:0] m_op;
    bit [2:0] m_ld;
    bit       m_valid, m_err;
    bit       m_level [4];
    bit       m_pend  [4];
    bit       m_raw_q [4][$];
    bit       m_syn_q [4][$];

    always @(posedge clk or negedge rst_n) begin : model
        bit armed;
        bit raw [4];
        bit synced;
        bit all_diff;
        if (!rst_n) begin
            m_a = 0; m_b = 0; m_op = 0; m_ld = 0; m_valid = 0; m_err = 0;
            for (int b = 0; b < 4; b++) begin
                m_level[b] = 0;
                m_pend[b]  = 0;
                m_raw_q[b].delete();
                m_syn_q[b].delete();
            end
        end else begin
            armed   = (m_ld == 3'b111);
            m_valid = m_pend[3] && armed;
            m_err   = (m_pend[3] && !armed) || (m_pend[2] && !legal(bus.i_switch[5:0]));
            if (m_pend[0]) begin m_a = bus.i_switch; m_ld[0] = 1'b1; end
            if (m_pend[1]) begin m_b = bus.i_switch; m_ld[1] = 1'b1; end
            if (m_pend[2] && legal(bus.i_switch[5:0])) begin
                m_op = bus.i_switch[5:0];
                m_ld[2] = 1'b1;
            end
            raw[0] = bus.i_boton_1; raw[1] = bus.i_boton_2;
            raw[2] = bus.i_boton_3; raw[3] = bus.i_boton_4;
            for (int b = 0; b < 4; b++) begin
                synced = (m_raw_q[b].size() == 2) ? m_raw_q[b][0] : 1'b0;
                m_raw_q[b].push_back(raw[b]);
                if (m_raw_q[b].size() > 2) void'(m_raw_q[b].pop_front());
                m_syn_q[b].push_back(synced);
                if (m_syn_q[b].size() > N_DEBOUNCE) void'(m_syn_q[b].pop_front());
                all_diff = (m_syn_q[b].size() == N_DEBOUNCE);
                for (int i = 0; i < m_syn_q[b].size(); i++)
                    if (m_syn_q[b][i] == m_level[b]) all_diff = 1'b0;
                m_pend[b] = 1'b0;
                if (all_diff) begin
                    m_level[b] = !m_level[b];
                    m_syn_q[b].delete();
                    m_pend[b]  = m_level[b];
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    int       v_cnt, e_cnt;
    bit [7:0] cap_a, cap_b;
    bit [5:0] cap_op;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_btn(input bit [3:0] m);
        bus.i_boton_1 = m[0];
        bus.i_boton_2 = m[1];
        bus.i_boton_3 = m[2];
        bus.i_boton_4 = m[3];
    endtask

    task automatic sample();
        if (bus.o_valid === 1'b1) begin
            v_cnt++;
            cap_a  = bus.o_dato_a;
            cap_b  = bus.o_dato_b;
            cap_op = bus.o_opcode;
        end
        if (bus.o_err === 1'b1) e_cnt++;
    endtask

    task automatic press(input bit [3:0] m, input int hold);
        v_cnt = 0;
        e_cnt = 0;
        set_btn(m);
        repeat (hold) begin tick(); sample(); end
        set_btn(4'b0000);
        repeat (8) begin tick(); sample(); end
    endtask

    initial begin
        bus.i_switch = '0;
        set_btn(4'b0000);
        #1 rst_n = 1'b0;
        fork
            begin : stim
                repeat (3) tick();
                chk("rst_a", bus.o_dato_a, 0);
                chk("rst_b", bus.o_dato_b, 0);
                chk("rst_op", bus.o_opcode, 0);
                chk("rst_loaded", bus.o_loaded, 0);
                chk("rst_valid", bus.o_valid, 0);
                chk("rst_err", bus.o_err, 0);
                #1 rst_n = 1'b1;
                repeat (2) tick();

                // Issue with only A and B loaded
                bus.i_switch = 8'h11; press(4'b0001, 4);
                bus.i_switch = 8'h22; press(4'b0010, 4);
                press(4'b1000, 4);
                chk("empty_issue_err", e_cnt, 1);
                chk("empty_issue_valid", v_cnt, 0);
                chk("empty_loaded", bus.o_loaded, 3'b011);

                // Illegal opcode while empty
                bus.i_switch = 8'h3F; press(4'b0100, 4);
                chk("illegal_err", e_cnt, 1);
                chk("illegal_op", bus.o_opcode, 0);
                chk("illegal_loaded", bus.o_loaded, 3'b011);

                // Full load and issue
                bus.i_switch = 8'hC0; press(4'b0001, 4);
                bus.i_switch = 8'h01; press(4'b0010, 4);
                bus.i_switch = 8'h20; press(4'b0100, 4);
                chk("armed_loaded", bus.o_loaded, 3'b111);
                press(4'b1000, 4);
                chk("issue1_valid", v_cnt, 1);
                chk("issue1_err", e_cnt, 0);
                chk("issue1_a", cap_a, 8'hC0);
                chk("issue1_b", cap_b, 8'h01);
                chk("issue1_op", cap_op, 6'h20);

                // Opcode reload and reissue
                bus.i_switch = 8'h22; press(4'b0100, 4);
                press(4'b1000, 4);
                chk("issue2_valid", v_cnt, 1);
                chk("issue2_a", cap_a, 8'hC0);
                chk("issue2_b", cap_b, 8'h01);
                chk("issue2_op", cap_op, 6'h22);

                // Illegal opcode while armed keeps the old code
                bus.i_switch = 8'h3F; press(4'b0100, 4);
                chk("armed_illegal_err", e_cnt, 1);
                chk("armed_illegal_op", bus.o_opcode, 6'h22);
                chk("armed_illegal_loaded", bus.o_loaded, 3'b111);
                press(4'b1000, 4);
                chk("reissue_valid", v_cnt, 1);

                // One-cycle glitch, then a three-cycle press with exact latency
                bus.i_switch = 8'h5A; press(4'b0001, 1);
                chk("glitch_a", bus.o_dato_a, 8'hC0);
                chk("glitch_err", e_cnt, 0);
                set_btn(4'b0001);
                repeat (3) tick();
                set_btn(4'b0000);
                tick();
                chk("lat_early_a", bus.o_dato_a, 8'hC0);
                tick();
                chk("lat_load_a", bus.o_dato_a, 8'h5A);
                repeat (8) tick();

                // Reset in the middle of a B press, button held through release
                bus.i_switch = 8'h99;
                set_btn(4'b0010);
                repeat (3) tick();
                rst_n = 1'b0;
                #1;
                chk("midrst_a", bus.o_dato_a, 0);
                chk("midrst_b", bus.o_dato_b, 0);
                chk("midrst_op", bus.o_opcode, 0);
                chk("midrst_loaded", bus.o_loaded, 0);
                repeat (3) tick();
                #1 rst_n = 1'b1;
                repeat (N_DEBOUNCE + 2) tick();
                chk("postrst_early", bus.o_loaded, 3'b000);
                tick();
                chk("postrst_loaded", bus.o_loaded, 3'b010);
                chk("postrst_b", bus.o_dato_b, 8'h99);
                set_btn(4'b0000);
                repeat (8) tick();

                // Coinciding error causes give a single err pulse
                bus.i_switch = 8'h3F; press(4'b1100, 4);
                chk("dual_err", e_cnt, 1);
                chk("dual_valid", v_cnt, 0);
                chk("dual_loaded", bus.o_loaded, 3'b010);
                chk("dual_op", bus.o_opcode, 0);
                repeat (2) tick();
            end
            forever begin
                @(negedge clk);
                chk("cmp_a", bus.o_dato_a, m_a);
                chk("cmp_b", bus.o_dato_b, m_b);
                chk("cmp_op", bus.o_opcode, m_op);
                chk("cmp_loaded", bus.o_loaded, m_ld);
                chk("cmp_valid", bus.o_valid, m_valid);
                chk("cmp_err", bus.o_err, m_err);
            end
        join_any
        disable fork;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
